// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - shared size codes, FSM states and size-to-length helper
//
// Purpose : common definitions for the store alignment unit.
// Contents: SZ_* request size codes, state_e FSM encoding, size_to_len().

package store_align_unit_pkg;

    localparam logic [2:0] SZ_BYTE   = 3'b000;
    localparam logic [2:0] SZ_HALF   = 3'b010;
    localparam logic [2:0] SZ_WORD   = 3'b100;
    localparam logic [2:0] SZ_DOUBLE = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Length in bytes for a size code; 0 marks an illegal code.
    function automatic logic [3:0] size_to_len(input logic [2:0] size);
        case (size)
            SZ_BYTE:   return 4'd1;
            SZ_HALF:   return 4'd2;
            SZ_WORD:   return 4'd4;
            SZ_DOUBLE: return 4'd8;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_rotate.sv
// rtl/store_lane_rotate.sv - combinational byte-lane rotation and strobe generation
//
// Purpose : places the first len bytes of data_in onto lanes (off+i) mod NB and
//           builds the write strobes for the first and (optional) second beat.
// Ports   : data_in  - right-justified store data
//           off      - byte offset of the start address within a beat
//           len      - store length in bytes (1/2/4/8)
//           data_out - lane-placed data, unused lanes zero
//           strb_lo  - strobes for the first beat
//           strb_hi  - strobes for the second beat (non-zero only when off+len > NB)

module store_lane_rotate #(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [OFF_W-1:0]  off,
    input  logic [3:0]        len,
    output logic [DATA_W-1:0] data_out,
    output logic [NB-1:0]     strb_lo,
    output logic [NB-1:0]     strb_hi
);

    logic [OFF_W-1:0] lane;
    logic [4:0]       first;
    logic [4:0]       last_excl;

    always_comb begin
        data_out  = '0;
        strb_lo   = '0;
        strb_hi   = '0;
        lane      = '0;
        first     = 5'(off);
        last_excl = 5'(off) + 5'(len);

        // The lane index wraps naturally in OFF_W bits, giving the mod-NB rotation.
        for (int i = 0; i < NB; i++) begin
            if (4'(i) < len) begin
                lane = off + OFF_W'(i);
                data_out[lane*8 +: 8] = data_in[i*8 +: 8];
            end
        end

        // Strobes are the window [off, off+len) over two consecutive beats.
        for (int j = 0; j < NB; j++) begin
            strb_lo[j] = (5'(j) >= first) && (5'(j) < last_excl);
            strb_hi[j] = (5'(j + NB) >= first) && (5'(j + NB) < last_excl);
        end
    end

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store alignment unit, splits misaligned stores into bus beats
//
// Purpose : accepts one store request at a time, places its data on byte lanes
//           and issues one or two aligned write beats, then a one-cycle response.
// Ports   : req_valid/req_ready/req_addr/req_data/req_size - store request
//           bus_valid/bus_ready/bus_addr/bus_wdata/bus_wstrb - memory write beat
//           rsp_valid/rsp_err                                - completion pulse

module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1,
    localparam int NB      = DATA_W / 8,
    localparam int OFF_W   = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_size,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [NB-1:0]     bus_wstrb,
    output logic              rsp_valid,
    output logic              rsp_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     strb0_q, strb0_d;
    logic [NB-1:0]     strb1_q, strb1_d;
    logic              err_q,   err_d;

    logic [3:0]        req_len;
    logic [DATA_W-1:0] rot_data;
    logic [NB-1:0]     rot_strb_lo;
    logic [NB-1:0]     rot_strb_hi;
    logic              size_bad;
    logic              misaligned;
    logic              req_err;

    assign req_len = size_to_len(req_size);

    store_lane_rotate #(
        .DATA_W (DATA_W)
    ) u_rotate (
        .data_in  (req_data),
        .off      (req_addr[OFF_W-1:0]),
        .len      (req_len),
        .data_out (rot_data),
        .strb_lo  (rot_strb_lo),
        .strb_hi  (rot_strb_hi)
    );

    // A double store does not fit a 32-bit beat, so it is illegal there.
    assign size_bad   = (req_len == 4'd0) || (int'(req_len) > NB);
    // Any strobe spilling into the second beat means the store crosses a beat boundary.
    assign misaligned = |rot_strb_hi;
    // The I/O region check looks at the start address only.
    assign req_err    = size_bad || req_addr[ADDR_W-1] || (misaligned && (SPLIT_EN == 0));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb0_d   = strb0_q;
        strb1_d   = strb1_q;
        err_d     = err_q;
        req_ready = 1'b0;
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d = rot_data;
                    strb0_d = rot_strb_lo;
                    strb1_d = rot_strb_hi;
                    err_d   = req_err;
                    state_d = req_err ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                bus_valid = 1'b1;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                bus_wstrb = strb0_q;
                if (bus_ready) begin
                    state_d = (|strb1_q) ? ST_BEAT1 : ST_RESP;
                end
            end
            ST_BEAT1: begin
                bus_valid = 1'b1;
                // Wraps modulo 2^ADDR_W; the beat is issued even if the MSB becomes set.
                bus_addr  = addr_q + ADDR_W'(NB);
                bus_wdata = wdata_q;
                bus_wstrb = strb1_q;
                if (bus_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb0_q <= '0;
            strb1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb0_q <= strb0_d;
            strb1_q <= strb1_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - self-checking bench for store_align_unit (32-bit bus)

module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr, req_data;
    logic [2:0]  req_size;
    logic        bus_ready;

    logic        req_ready_a, bus_valid_a, rsp_valid_a, rsp_err_a;
    logic [31:0] bus_addr_a, bus_wdata_a;
    logic [3:0]  bus_wstrb_a;
    logic        req_ready_b, bus_valid_b, rsp_valid_b, rsp_err_b;
    logic [31:0] bus_addr_b, bus_wdata_b;
    logic [3:0]  bus_wstrb_b;

    always #5 clk = ~clk;

    // Unit A splits misaligned stores, unit B rejects them.
    store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .bus_valid(bus_valid_a), .bus_ready(bus_ready), .bus_addr(bus_addr_a),
        .bus_wdata(bus_wdata_a), .bus_wstrb(bus_wstrb_a),
        .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a)
    );

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .bus_valid(bus_valid_b), .bus_ready(bus_ready), .bus_addr(bus_addr_b),
        .bus_wdata(bus_wdata_b), .bus_wstrb(bus_wstrb_b),
        .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b)
    );

    logic        use_b = 1'b0;
    logic        m_req_ready, m_bus_valid, m_rsp_valid, m_rsp_err;
    logic [31:0] m_bus_addr, m_bus_wdata;
    logic [3:0]  m_bus_wstrb;

    assign m_req_ready = use_b ? req_ready_b : req_ready_a;
    assign m_bus_valid = use_b ? bus_valid_b : bus_valid_a;
    assign m_rsp_valid = use_b ? rsp_valid_b : rsp_valid_a;
    assign m_rsp_err   = use_b ? rsp_err_b   : rsp_err_a;
    assign m_bus_addr  = use_b ? bus_addr_b  : bus_addr_a;
    assign m_bus_wdata = use_b ? bus_wdata_b : bus_wdata_a;
    assign m_bus_wstrb = use_b ? bus_wstrb_b : bus_wstrb_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: walks the bytes of the store by byte address.
    bit          exp_err;
    int          exp_n;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_strb [2];
    logic [31:0] exp_wdata;

    task automatic model(input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] size, input bit split_en);
        int          len;
        int          lane;
        int          beat;
        logic [31:0] a;
        logic [31:0] base0;
        case (size)
            3'b000:  len = 1;
            3'b010:  len = 2;
            3'b100:  len = 4;
            default: len = 0;   // includes the double code, too wide for a 32-bit bus
        endcase
        exp_err = (len == 0) || addr[31] || (!split_en && (int'(addr % 4) + len > 4));
        exp_n = 0;
        exp_wdata = '0;
        exp_strb[0] = '0;
        exp_strb[1] = '0;
        base0 = addr & ~32'h3;
        exp_addr[0] = base0;
        exp_addr[1] = base0 + 32'd4;
        if (!exp_err) begin
            for (int i = 0; i < len; i++) begin
                a = addr + 32'(i);
                beat = ((a & ~32'h3) == base0) ? 0 : 1;
                lane = int'(a % 4);
                exp_wdata[8*lane +: 8] = data[8*i +: 8];
                exp_strb[beat][lane] = 1'b1;
                if (beat + 1 > exp_n) exp_n = beat + 1;
            end
        end
    endtask

    // mode 0: bus_ready always 1, mode 1: random, mode 2: low for 5 cycles then 1.
    // hold keeps req_valid asserted while the unit is busy.
    task automatic run_txn(input bit b, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] size, input int mode, input bit hold);
        int cyc;
        int k;
        bit done;
        model(addr, data, size, b ? 1'b0 : 1'b1);
        @(negedge clk);
        use_b     = b;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        req_valid_a = !b;
        req_valid_b = b;
        bus_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'($urandom % 2) : 1'b1;
        #1;
        chk("idle_req_ready", 32'(m_req_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold) begin
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
        end
        cyc = 1;
        k = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            if (m_bus_valid) begin
                chk("beat_expected", 32'(k < exp_n), 32'd1);
                if (k < exp_n) begin
                    chk("bus_addr",  m_bus_addr,         exp_addr[k]);
                    chk("bus_wstrb", 32'(m_bus_wstrb),   32'(exp_strb[k]));
                    chk("bus_wdata", m_bus_wdata,        exp_wdata);
                end
                chk("busy_req_ready", 32'(m_req_ready), 32'd0);
            end else begin
                chk("quiet_bus", {m_bus_addr ^ m_bus_wdata, 28'd0} | 32'(m_bus_wstrb)
                    | 32'(m_bus_addr != 0) | 32'(m_bus_wdata != 0), 32'd0);
            end
            if (m_rsp_valid) begin
                chk("rsp_err",     32'(m_rsp_err), 32'(exp_err));
                chk("beats_done",  32'(k),         32'(exp_n));
                if (mode == 0) chk("rsp_latency", 32'(cyc), 32'(1 + exp_n));
                req_valid_a = 1'b0;
                req_valid_b = 1'b0;
                done = 1'b1;
            end else begin
                if (mode == 1) bus_ready = 1'($urandom % 2);
                else if (mode == 2) bus_ready = (cyc >= 5);
                else bus_ready = 1'b1;
                if (m_bus_valid && bus_ready) k++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
        end
        @(posedge clk); #1;
        chk("rsp_one_cycle",   32'(m_rsp_valid), 32'd0);
        chk("back_idle_ready", 32'(m_req_ready), 32'd1);
        chk("back_idle_valid", 32'(m_bus_valid), 32'd0);
    endtask

    logic [31:0] r_addr;
    logic [2:0]  r_size;

    initial begin
        rst_n = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_size = '0;
        bus_ready = 1'b0;

        #1;
        chk("rst_req_ready_a", 32'(req_ready_a), 32'd1);
        chk("rst_req_ready_b", 32'(req_ready_b), 32'd1);
        chk("rst_bus_valid",   32'(bus_valid_a | bus_valid_b), 32'd0);
        chk("rst_bus_addr",    bus_addr_a | bus_addr_b, 32'd0);
        chk("rst_bus_wdata",   bus_wdata_a | bus_wdata_b, 32'd0);
        chk("rst_bus_wstrb",   32'(bus_wstrb_a | bus_wstrb_b), 32'd0);
        chk("rst_rsp",         32'({rsp_valid_a, rsp_err_a, rsp_valid_b, rsp_err_b}), 32'd0);
        #11;
        rst_n = 1'b1;

        // Aligned word, byte at top lane, split word, rejected split word.
        run_txn(1'b0, 32'h0000_0100, 32'hAABB_CCDD, 3'b100, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0203, 32'h0000_005A, 3'b000, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0106, 32'h1122_3344, 3'b100, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0106, 32'h1122_3344, 3'b100, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0100, 32'h1122_3344, 3'b110, 0, 1'b0);
        run_txn(1'b1, 32'h8000_0000, 32'h1122_3344, 3'b100, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0100, 32'h1122_3344, 3'b110, 0, 1'b0);
        run_txn(1'b0, 32'h8000_0000, 32'h1122_3344, 3'b100, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0100, 32'h1122_3344, 3'b011, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0013, 32'h0000_BEEF, 3'b010, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0012, 32'h0000_BEEF, 3'b010, 0, 1'b0);
        // Second beat address crosses into the MSB region and is still issued.
        run_txn(1'b0, 32'h7FFF_FFFE, 32'hCAFE_F00D, 3'b100, 0, 1'b0);
        // Stalled beats with the request held high throughout.
        run_txn(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 3'b100, 2, 1'b1);
        run_txn(1'b0, 32'h0000_03FF, 32'h0000_A55A, 3'b010, 2, 1'b1);

        // Reset while the second beat is on the bus.
        @(negedge clk);
        use_b = 1'b0;
        req_addr = 32'h0000_0106;
        req_data = 32'h1122_3344;
        req_size = 3'b100;
        req_valid_a = 1'b1;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        chk("rstmid_beat0_addr", bus_addr_a, 32'h0000_0104);
        @(posedge clk); #1;
        chk("rstmid_beat1_valid", 32'(bus_valid_a), 32'd1);
        chk("rstmid_beat1_addr",  bus_addr_a, 32'h0000_0108);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid_drop", 32'(bus_valid_a), 32'd0);
        chk("rstmid_ready",      32'(req_ready_a), 32'd1);
        chk("rstmid_addr_zero",  bus_addr_a, 32'd0);
        @(posedge clk); #1;
        chk("rstmid_no_rsp0", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_no_rsp1", 32'(rsp_valid_a), 32'd0);
        chk("rstmid_ready1",  32'(req_ready_a), 32'd1);
        run_txn(1'b0, 32'h0000_0101, 32'h0000_7788, 3'b010, 0, 1'b0);

        // Randomized requests against the model.
        for (int n = 0; n < 60; n++) begin
            r_addr = $urandom;
            if ($urandom_range(0, 7) != 0) r_addr[31] = 1'b0;
            if ($urandom_range(0, 3) == 0) r_size = 3'($urandom_range(0, 7));
            else r_size = ($urandom_range(0, 2) == 0) ? 3'b000
                        : ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
            run_txn(1'($urandom % 2), r_addr, $urandom, r_size, 1, 1'($urandom % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
